counter_ctrl: RTL
=================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the controlled counter and of all value ports.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-low.
REQ-004 start_i  input  1  request to start a timing run; sampled in IDLE only.
REQ-005 stop_i  input  1  abort request; sampled in any state.
REQ-006 mode_i  input  1  0 = one-shot, 1 = periodic; captured on accepted start.
REQ-007 init_i  input  WIDTH  counter start value; captured on accepted start.
REQ-008 term_i  input  WIDTH  terminal value; captured on accepted start.
REQ-009 irq_ack_i  input  1  clears irq_o.
REQ-010 cnt_i  input  WIDTH  current counter value, from the counter's dat_o.
REQ-011 cnt_clr_o  output  1  drives the counter's clr_i.
REQ-012 cnt_en_o  output  1  drives the counter's en_i (counter increments by 1 per enabled cycle, modulo 2^WIDTH).
REQ-013 cnt_we_o  output  1  drives the counter's we_i.
REQ-014 cnt_dat_o  output  WIDTH  drives the counter's dat_i.
REQ-015 busy_o  output  1  high whenever state is not IDLE.
REQ-016 done_o  output  1  one-cycle pulse per completed run.
REQ-017 irq_o  output  1  sticky completion flag.

Function
REQ-018 States SHALL be IDLE, LOAD, RUN, CLR; at most one of cnt_clr_o, cnt_we_o, cnt_en_o SHALL be high in any cycle.
REQ-019 IDLE: start_i=1 and stop_i=0 -> capture mode_i/init_i/term_i into MODE/INIT/TV, go LOAD; otherwise stay; all cnt_* outputs 0.
REQ-020 LOAD: cnt_we_o=1, cnt_dat_o=INIT for exactly one cycle, then RUN.
REQ-021 RUN, cnt_i != TV: cnt_en_o=1, stay RUN.
REQ-022 RUN, cnt_i == TV (terminal cycle): cnt_en_o=0; MODE=1 -> LOAD, MODE=0 -> IDLE; done_o=1 in the following cycle only.
REQ-023 Run length: N = (TV - INIT) mod 2^WIDTH enabled cycles; TV < INIT wraps through 2^WIDTH-1 to 0; TV == INIT -> zero enabled cycles, terminal on first RUN cycle.
REQ-024 Periodic mode: consecutive done_o pulses exactly N+2 cycles apart.
REQ-025 cnt_dat_o SHALL equal INIT in all states (0 after reset until first capture).
REQ-026 stop_i=1 in LOAD or RUN -> next state CLR, no done_o, irq_o unaffected; stop_i has priority over a same-cycle terminal condition.
REQ-027 CLR: cnt_clr_o=1 for exactly one cycle, then IDLE; start_i ignored in CLR.
REQ-028 start_i ignored outside IDLE; start_i and stop_i together in IDLE -> no start.
REQ-029 irq_o set in the cycle done_o is high; cleared the cycle after irq_ack_i=1; set and ack in same cycle -> irq_o stays 1.
REQ-030 done_o in IDLE (one-shot completion) SHALL not block a start sampled in that same cycle.

Reset
REQ-031 rst_i=0 at a clock edge -> next cycle state IDLE, MODE/INIT/TV=0, busy_o, done_o, irq_o, cnt_clr_o, cnt_en_o, cnt_we_o, cnt_dat_o all 0, regardless of state or other inputs.
REQ-032 Reset mid-run SHALL suppress any pending done_o pulse; counter value is not cleared by this block.

Verification
REQ-033 Reset: hold rst_i=0 two cycles during RUN -> all outputs 0 the cycle after first low edge; release -> IDLE, busy_o=0.
REQ-034 One-shot INIT=3 TV=7, start at cycle 0 -> cycle 1 cnt_we_o=1 dat=3; cycles 2-5 cnt_en_o=1; cycle 6 terminal; cycle 7 done_o=1, irq_o=1, busy_o=0.
REQ-035 Periodic INIT=0 TV=2 -> done_o every 4 cycles; stop_i in RUN -> one cycle cnt_clr_o=1, then IDLE, no further done_o.
REQ-036 Wrap INIT=250 TV=4 one-shot -> exactly 10 cnt_en_o cycles, cnt_i passes 255->0, single done_o.
REQ-037 TV=INIT=5 periodic -> done_o every 2 cycles, cnt_en_o never high.
REQ-038 irq_ack_i with done_o same cycle -> irq_o stays 1; ack alone next -> irq_o 0; start+stop in IDLE and start in RUN -> no state change.

Source files
------------

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - sequencer that loads, runs and clears an external up-counter
module counter_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] init_i,
  input  logic [WIDTH-1:0] term_i,
  input  logic             irq_ack_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             cnt_clr_o,
  output logic             cnt_en_o,
  output logic             cnt_we_o,
  output logic [WIDTH-1:0] cnt_dat_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             irq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    CLR  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             mode_q;
  logic [WIDTH-1:0] init_q;
  logic [WIDTH-1:0] tv_q;
  logic             done_q;
  logic             irq_q;
  logic             accept;
  logic             at_term;

  assign accept  = (state == IDLE) && start_i && !stop_i;
  assign at_term = (cnt_i == tv_q);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      mode_q <= 1'b0;
      init_q <= '0;
      tv_q   <= '0;
      done_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mode_q <= mode_i;
        init_q <= init_i;
        tv_q   <= term_i;
      end
      // stop wins over a terminal cycle, so an aborted run never reports done
      done_q <= (state == RUN) && at_term && !stop_i;
      // the visible flag already includes done_o, so an ack in that cycle cannot lose it
      irq_q  <= done_q || (irq_q && !irq_ack_i);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
      LOAD: state_nxt = stop_i ? CLR : RUN;
      RUN: begin
        if (stop_i)       state_nxt = CLR;
        else if (at_term) state_nxt = mode_q ? LOAD : IDLE;
      end
      CLR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr_o = (state == CLR);
    cnt_we_o  = (state == LOAD);
    cnt_en_o  = (state == RUN) && !at_term;
    cnt_dat_o = init_q;
    busy_o    = (state != IDLE);
    done_o    = done_q;
    irq_o     = irq_q || done_q;
  end

endmodule
